// File: rtl/pcie_dma_desc_issuer_pkg.sv
// Shared constants for the DMA descriptor issuer.
// Completion records are packed as {cookie, error}.
package pcie_dma_desc_issuer_pkg;

    localparam int         ERR_WIDTH   = 4;
    localparam logic [3:0] ERR_OK      = 4'h0;
    localparam logic [3:0] ERR_BAD_LEN = 4'hE;

endpackage

// File: rtl/pcie_dma_desc_issuer_fifo.sv
// Completion FIFO: record in data, owning tag in user.
// No s_ready: the issuer never holds more records than DEPTH.
module pcie_dma_desc_issuer_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 20,
    parameter int USER_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic [USER_W-1:0] s_user,
    input  logic              s_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [USER_W-1:0] m_user,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W+USER_W-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic                     pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign m_valid          = (count != '0);
    assign pop              = m_valid && m_ready;
    assign {m_data, m_user} = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s_valid) wr_ptr <= nxt(wr_ptr);
            if (pop)     rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(s_valid) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (s_valid) mem[wr_ptr] <= {s_data, s_user};
    end

endmodule

// File: rtl/pcie_dma_desc_issuer.sv
// One-direction DMA descriptor issuer: tag allocation,
// descriptor issue, status-to-cookie matching and completions.
module pcie_dma_desc_issuer
    import pcie_dma_desc_issuer_pkg::*;
#(
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH  = 48,
    parameter int LEN_WIDTH       = 16,
    parameter int DMA_TAG_WIDTH   = 8,
    parameter int TAG_COUNT       = 16,
    parameter int COOKIE_WIDTH    = 16,
    parameter int MAX_LEN         = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PCIE_ADDR_WIDTH-1:0]    req_pcie_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_axi_addr,
    input  logic [LEN_WIDTH-1:0]          req_len,
    input  logic [COOKIE_WIDTH-1:0]       req_cookie,
    input  logic                          req_valid,
    output logic                          req_ready,
    output logic [PCIE_ADDR_WIDTH-1:0]    m_desc_pcie_addr,
    output logic [AXI_ADDR_WIDTH-1:0]     m_desc_axi_addr,
    output logic [LEN_WIDTH-1:0]          m_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]      m_desc_tag,
    output logic                          m_desc_valid,
    input  logic                          m_desc_ready,
    input  logic [DMA_TAG_WIDTH-1:0]      s_status_tag,
    input  logic [ERR_WIDTH-1:0]          s_status_error,
    input  logic                          s_status_valid,
    output logic [COOKIE_WIDTH-1:0]       cmp_cookie,
    output logic [ERR_WIDTH-1:0]          cmp_error,
    output logic                          cmp_valid,
    input  logic                          cmp_ready,
    output logic [$clog2(TAG_COUNT+1)-1:0] outstanding,
    output logic                          stat_spurious
);

    localparam int TW = $clog2(TAG_COUNT);
    localparam int OW = $clog2(TAG_COUNT + 1);
    localparam int RW = COOKIE_WIDTH + ERR_WIDTH;
    localparam logic [LEN_WIDTH-1:0]   MAX_L   = LEN_WIDTH'(MAX_LEN);
    localparam logic [DMA_TAG_WIDTH:0] TAG_LIM = (DMA_TAG_WIDTH + 1)'(TAG_COUNT);

    // pend: a completion record for this tag is queued or in flight
    logic [TAG_COUNT-1:0]    busy;
    logic [TAG_COUNT-1:0]    pend;
    logic [COOKIE_WIDTH-1:0] cookie_mem [TAG_COUNT];

    logic          free_any;
    logic [TW-1:0] free_idx;
    logic          len_bad;
    logic [TW-1:0] st_idx;
    logic          st_ok;
    logic          acc;
    logic          pop;
    logic          push_valid;
    logic [RW-1:0] push_data;
    logic [TW-1:0] push_tag;
    logic [RW-1:0] cmp_rec;
    logic [TW-1:0] pop_tag;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = TW'(i);
            end
        end
    end

    assign len_bad = (req_len == '0) || (req_len > MAX_L);
    assign st_idx  = s_status_tag[TW-1:0];
    assign st_ok   = s_status_valid && ({1'b0, s_status_tag} < TAG_LIM) &&
                     busy[st_idx] && !pend[st_idx];

    // a reject waits out a status cycle so the push slot is never shared
    assign req_ready = !rst && free_any &&
                       (!m_desc_valid || m_desc_ready) &&
                       !(len_bad && s_status_valid);
    assign acc = req_valid && req_ready;
    assign pop = cmp_valid && cmp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy             <= '0;
            pend             <= '0;
            push_valid       <= 1'b0;
            push_data        <= '0;
            push_tag         <= '0;
            stat_spurious    <= 1'b0;
            outstanding      <= '0;
            m_desc_valid     <= 1'b0;
            m_desc_pcie_addr <= '0;
            m_desc_axi_addr  <= '0;
            m_desc_len       <= '0;
            m_desc_tag       <= '0;
        end else begin
            stat_spurious <= s_status_valid && !st_ok;
            push_valid    <= st_ok || (acc && len_bad);
            if (st_ok) begin
                push_data    <= {cookie_mem[st_idx], s_status_error};
                push_tag     <= st_idx;
                pend[st_idx] <= 1'b1;
            end else if (acc && len_bad) begin
                push_data <= {req_cookie, ERR_BAD_LEN};
                push_tag  <= free_idx;
            end
            if (pop) begin
                busy[pop_tag] <= 1'b0;
                pend[pop_tag] <= 1'b0;
            end
            if (acc) begin
                busy[free_idx] <= 1'b1;
                pend[free_idx] <= len_bad;
            end
            outstanding <= outstanding + OW'(acc) - OW'(pop);
            if (acc && !len_bad) begin
                m_desc_valid     <= 1'b1;
                m_desc_pcie_addr <= req_pcie_addr;
                m_desc_axi_addr  <= req_axi_addr;
                m_desc_len       <= req_len;
                m_desc_tag       <= DMA_TAG_WIDTH'(free_idx);
            end else if (m_desc_ready) begin
                m_desc_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) cookie_mem[free_idx] <= req_cookie;
    end

    pcie_dma_desc_issuer_fifo #(
        .DEPTH  (TAG_COUNT),
        .DATA_W (RW),
        .USER_W (TW)
    ) u_cmp_fifo (
        .clk     (clk),
        .rst     (rst),
        .s_data  (push_data),
        .s_user  (push_tag),
        .s_valid (push_valid),
        .m_data  (cmp_rec),
        .m_user  (pop_tag),
        .m_valid (cmp_valid),
        .m_ready (cmp_ready)
    );

    assign cmp_cookie = cmp_rec[RW-1:ERR_WIDTH];
    assign cmp_error  = cmp_rec[ERR_WIDTH-1:0];

endmodule

// File: tb/tb_pcie_dma_desc_issuer.sv
// Bench for pcie_dma_desc_issuer: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_pcie_dma_desc_issuer;

    logic        clk;
    logic        rst;
    logic [63:0] req_pcie_addr;
    logic [47:0] req_axi_addr;
    logic [15:0] req_len;
    logic [15:0] req_cookie;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] m_desc_pcie_addr;
    logic [47:0] m_desc_axi_addr;
    logic [15:0] m_desc_len;
    logic [7:0]  m_desc_tag;
    logic        m_desc_valid;
    logic        m_desc_ready;
    logic [7:0]  s_status_tag;
    logic [3:0]  s_status_error;
    logic        s_status_valid;
    logic [15:0] cmp_cookie;
    logic [3:0]  cmp_error;
    logic        cmp_valid;
    logic        cmp_ready;
    logic [4:0]  outstanding;
    logic        stat_spurious;

    int tests = 0;
    int fails = 0;

    pcie_dma_desc_issuer dut (
        .clk              (clk),
        .rst              (rst),
        .req_pcie_addr    (req_pcie_addr),
        .req_axi_addr     (req_axi_addr),
        .req_len          (req_len),
        .req_cookie       (req_cookie),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .m_desc_pcie_addr (m_desc_pcie_addr),
        .m_desc_axi_addr  (m_desc_axi_addr),
        .m_desc_len       (m_desc_len),
        .m_desc_tag       (m_desc_tag),
        .m_desc_valid     (m_desc_valid),
        .m_desc_ready     (m_desc_ready),
        .s_status_tag     (s_status_tag),
        .s_status_error   (s_status_error),
        .s_status_valid   (s_status_valid),
        .cmp_cookie       (cmp_cookie),
        .cmp_error        (cmp_error),
        .cmp_valid        (cmp_valid),
        .cmp_ready        (cmp_ready),
        .outstanding      (outstanding),
        .stat_spurious    (stat_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] ck;
        logic [3:0]  er;
        int          tag;
        int          vis;
    } rec_t;
    typedef struct {
        logic [63:0] pa;
        logic [47:0] aa;
        logic [15:0] len;
        int          tag;
    } desc_t;

    rec_t        mq[$];
    desc_t       md[$];
    bit          mbusy[16];
    logic [15:0] mcook[16];
    bit          spur_exp = 0;
    int          cyc = 0;
    bit          m_bad, m_rdy, m_cv, m_st, m_acc, m_pop;
    int          m_ft, m_stt;
    rec_t        m_r;
    desc_t       m_d;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 16; i++) if (mbusy[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < 16; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic bit m_queued(input int t);
        foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        m_bad = (req_len == 16'd0) || (req_len > 16'd4096);
        m_ft  = m_lowest();
        m_rdy = !rst && (m_ft >= 0) && (md.size() == 0 || m_desc_ready) &&
                !(m_bad && s_status_valid);
        m_cv  = (mq.size() > 0) && (mq[0].vis <= cyc);
        chk("req_ready", req_ready, m_rdy);
        chk("outstanding", outstanding, 64'(m_count()));
        chk("stat_spurious", stat_spurious, spur_exp);
        chk("m_desc_valid", m_desc_valid, md.size() > 0);
        if (md.size() > 0) begin
            chk("m_desc_pcie_addr", m_desc_pcie_addr, md[0].pa);
            chk("m_desc_axi_addr", m_desc_axi_addr, 64'(md[0].aa));
            chk("m_desc_len", m_desc_len, 64'(md[0].len));
            chk("m_desc_tag", m_desc_tag, 64'(md[0].tag));
        end
        chk("cmp_valid", cmp_valid, m_cv);
        if (m_cv) begin
            chk("cmp_cookie", cmp_cookie, 64'(mq[0].ck));
            chk("cmp_error", cmp_error, 64'(mq[0].er));
        end
        if (rst) begin
            mq.delete();
            md.delete();
            for (int i = 0; i < 16; i++) mbusy[i] = 1'b0;
            spur_exp = 1'b0;
        end else begin
            m_stt = int'(s_status_tag);
            m_st  = 1'b0;
            if (s_status_valid && m_stt < 16)
                m_st = mbusy[m_stt] && !m_queued(m_stt);
            m_acc    = req_valid && m_rdy;
            m_pop    = m_cv && cmp_ready;
            spur_exp = s_status_valid && !m_st;
            if (md.size() > 0 && m_desc_ready) m_d = md.pop_front();
            if (m_pop) begin
                mbusy[mq[0].tag] = 1'b0;
                m_r = mq.pop_front();
            end
            if (m_st)
                mq.push_back('{mcook[m_stt], s_status_error, m_stt, cyc + 2});
            if (m_acc) begin
                mbusy[m_ft] = 1'b1;
                mcook[m_ft] = req_cookie;
                if (m_bad)
                    mq.push_back('{req_cookie, 4'hE, m_ft, cyc + 2});
                else
                    md.push_back('{req_pcie_addr, req_axi_addr, req_len, m_ft});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] len, input logic [15:0] ck);
        bit got = 1'b0;
        req_pcie_addr = {32'hABCD_0000, 16'h0, ck};
        req_axi_addr  = {32'h0001_0000, ck};
        req_len       = len;
        req_cookie    = ck;
        req_valid     = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            got = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("send_accept", got, 1'b1);
    endtask

    task automatic status(input logic [7:0] tag, input logic [3:0] er);
        s_status_tag   = tag;
        s_status_error = er;
        s_status_valid = 1'b1;
        tick();
        s_status_valid = 1'b0;
    endtask

    task automatic take(input string nm, input logic [15:0] ck, input logic [3:0] er);
        chk({nm, "_valid"}, cmp_valid, 1'b1);
        chk({nm, "_cookie"}, cmp_cookie, ck);
        chk({nm, "_error"}, cmp_error, er);
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ck3 [3];
        logic [3:0]  er3 [3];
        rst = 1'b1;
        req_pcie_addr = '0; req_axi_addr = '0; req_len = '0;
        req_cookie = '0; req_valid = 1'b0;
        m_desc_ready = 1'b1; cmp_ready = 1'b0;
        s_status_tag = '0; s_status_error = '0; s_status_valid = 1'b0;
        repeat (3) tick();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_cmp_valid", cmp_valid, 0);
        rst = 1'b0;
        tick();

        // 1: single request
        send(16'd64, 16'h1234);
        chk("t1_desc_valid", m_desc_valid, 1);
        chk("t1_desc_tag", m_desc_tag, 0);
        chk("t1_outstanding", outstanding, 1);
        status(8'd0, 4'd0);
        chk("t1_cmp_not_yet", cmp_valid, 0);
        tick();
        take("t1", 16'h1234, 4'h0);
        chk("t1_outstanding_after", outstanding, 0);

        // 2: fill all tags
        for (int i = 0; i < 16; i++) begin
            send(16'd128, 16'h0100 + 16'(i));
            chk("t2_tag", m_desc_tag, 64'(i));
        end
        req_valid = 1'b1;
        #1;
        chk("t2_full_ready", req_ready, 0);
        chk("t2_outstanding", outstanding, 16);
        req_valid = 1'b0;

        // 3: out-of-order statuses
        status(8'd5, 4'd0);
        status(8'd2, 4'd0);
        status(8'd9, 4'd3);
        repeat (2) tick();
        ck3 = '{16'h0105, 16'h0102, 16'h0109};
        er3 = '{4'h0, 4'h0, 4'h3};
        for (int i = 0; i < 3; i++) take("t3", ck3[i], er3[i]);
        chk("t3_outstanding", outstanding, 13);
        cmp_ready = 1'b1;
        for (int t = 0; t < 16; t++)
            if (t != 5 && t != 2 && t != 9) status(8'(t), 4'd0);
        repeat (4) tick();
        cmp_ready = 1'b0;
        chk("t3_drained", outstanding, 0);

        // 4: illegal lengths, then the largest legal one
        send(16'd0, 16'hAAAA);
        chk("t4_no_desc0", m_desc_valid, 0);
        send(16'd4097, 16'hBBBB);
        chk("t4_no_desc1", m_desc_valid, 0);
        repeat (2) tick();
        take("t4a", 16'hAAAA, 4'hE);
        take("t4b", 16'hBBBB, 4'hE);
        chk("t4_outstanding", outstanding, 0);
        send(16'd4096, 16'hCCCC);
        chk("t4_max_desc", m_desc_valid, 1);
        chk("t4_max_len", m_desc_len, 4096);
        chk("t4_max_tag", m_desc_tag, 0);

        // 5: spurious statuses
        status(8'd7, 4'd0);
        chk("t5_spur7", stat_spurious, 1);
        status(8'd20, 4'd0);
        chk("t5_spur20", stat_spurious, 1);
        tick();
        chk("t5_spur_clear", stat_spurious, 0);
        chk("t5_outstanding", outstanding, 1);
        chk("t5_no_cmp", cmp_valid, 0);
        status(8'd0, 4'd0);
        chk("t5_first_ok", stat_spurious, 0);
        status(8'd0, 4'd0);
        chk("t5_dup_spur", stat_spurious, 1);
        tick();
        take("t5", 16'hCCCC, 4'h0);
        chk("t5_outstanding_after", outstanding, 0);

        // 6: reset mid-operation
        send(16'd32, 16'hD000);
        send(16'd32, 16'hD001);
        status(8'd0, 4'd0);
        m_desc_ready = 1'b0;
        send(16'd32, 16'hD002);
        chk("t6_tag2", m_desc_tag, 2);
        chk("t6_busy3", outstanding, 3);
        tick();
        chk("t6_cmp_held", cmp_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", req_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("t6_desc_valid", m_desc_valid, 0);
        chk("t6_desc_tag", m_desc_tag, 0);
        chk("t6_desc_len", m_desc_len, 0);
        chk("t6_cmp_valid", cmp_valid, 0);
        chk("t6_cmp_cookie", cmp_cookie, 0);
        chk("t6_outstanding", outstanding, 0);
        chk("t6_spurious", stat_spurious, 0);
        status(8'd1, 4'd0);
        chk("t6_post_rst_spur", stat_spurious, 1);
        m_desc_ready = 1'b1;
        send(16'd16, 16'hE000);
        chk("t6_next_tag", m_desc_tag, 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
